// File: rtl/cache_mem_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cache_mem_arbiter_if
// Brief    : Bundle of icache, dcache and memory request/response signals
//            exchanged with the cache/memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface cache_mem_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int LINE_W = 128
);
    localparam int MASK_W = LINE_W / 8;

    // icache refill port
    logic              ic_req_valid;
    logic              ic_req_ready;
    logic [ADDR_W-1:0] ic_req_addr;
    logic              ic_resp_valid;
    logic [LINE_W-1:0] ic_resp_data;

    // dcache port
    logic              dc_req_valid;
    logic              dc_req_ready;
    logic              dc_req_rw;
    logic [ADDR_W-1:0] dc_req_addr;
    logic [LINE_W-1:0] dc_req_data;
    logic [MASK_W-1:0] dc_req_mask;
    logic              dc_resp_valid;
    logic [LINE_W-1:0] dc_resp_data;

    // main memory port
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_rw;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [LINE_W-1:0] mem_req_data;
    logic [MASK_W-1:0] mem_req_mask;
    logic              mem_resp_valid;
    logic [LINE_W-1:0] mem_resp_data;

    // Arbiter view
    modport slave (
        input  ic_req_valid, ic_req_addr,
        output ic_req_ready, ic_resp_valid, ic_resp_data,
        input  dc_req_valid, dc_req_rw, dc_req_addr, dc_req_data, dc_req_mask,
        output dc_req_ready, dc_resp_valid, dc_resp_data,
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    // Environment view (caches and memory)
    modport master (
        output ic_req_valid, ic_req_addr,
        input  ic_req_ready, ic_resp_valid, ic_resp_data,
        output dc_req_valid, dc_req_rw, dc_req_addr, dc_req_data, dc_req_mask,
        input  dc_req_ready, dc_resp_valid, dc_resp_data,
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );
endinterface
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cache_mem_arbiter
// Brief    : Round-robin arbiter between icache and dcache for a single
//            main-memory port, one outstanding transaction at a time.
// Revision : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int LINE_W = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    cache_mem_arbiter_if.slave    bus,
    output logic                  busy
);
    localparam int MASK_W = LINE_W / 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_dc_q, last_dc_d;     // dcache was granted last
    logic              owner_dc_q, owner_dc_d;   // current transaction owner
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] data_q, data_d;
    logic [MASK_W-1:0] mask_q, mask_d;
    logic              mem_valid_q, mem_valid_d;
    logic              ic_resp_valid_q, ic_resp_valid_d;
    logic              dc_resp_valid_q, dc_resp_valid_d;
    logic [LINE_W-1:0] ic_resp_data_q, ic_resp_data_d;
    logic [LINE_W-1:0] dc_resp_data_q, dc_resp_data_d;

    logic              w_idle;
    logic              w_grant_ic;
    logic              w_grant_dc;

    // Grant: a lone requester wins; on contention the one not served last wins
    always_comb begin
        w_idle     = (state_q == S_IDLE);
        w_grant_dc = w_idle && bus.dc_req_valid && (!bus.ic_req_valid || !last_dc_q);
        w_grant_ic = w_idle && bus.ic_req_valid && (!bus.dc_req_valid ||  last_dc_q);
    end

    // Next-state and registered-output computation for the transaction FSM
    always_comb begin
        state_d         = state_q;
        last_dc_d       = last_dc_q;
        owner_dc_d      = owner_dc_q;
        rw_d            = rw_q;
        addr_d          = addr_q;
        data_d          = data_q;
        mask_d          = mask_q;
        mem_valid_d     = mem_valid_q;
        ic_resp_valid_d = 1'b0;
        dc_resp_valid_d = 1'b0;
        ic_resp_data_d  = ic_resp_data_q;
        dc_resp_data_d  = dc_resp_data_q;

        case (state_q)
            S_IDLE: begin
                if (w_grant_dc) begin
                    owner_dc_d  = 1'b1;
                    last_dc_d   = 1'b1;
                    rw_d        = bus.dc_req_rw;
                    addr_d      = bus.dc_req_addr;
                    data_d      = bus.dc_req_data;
                    // Byte enables only mean something for writes
                    mask_d      = bus.dc_req_rw ? bus.dc_req_mask : '0;
                    mem_valid_d = 1'b1;
                    state_d     = S_ISSUE;
                end else if (w_grant_ic) begin
                    owner_dc_d  = 1'b0;
                    last_dc_d   = 1'b0;
                    rw_d        = 1'b0;
                    addr_d      = bus.ic_req_addr;
                    data_d      = '0;
                    mask_d      = '0;
                    mem_valid_d = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.mem_req_ready) begin
                    mem_valid_d = 1'b0;
                    // Writes are posted: no response is expected
                    state_d     = rw_q ? S_IDLE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.mem_resp_valid) begin
                    if (owner_dc_q) begin
                        dc_resp_data_d  = bus.mem_resp_data;
                        dc_resp_valid_d = 1'b1;
                    end else begin
                        ic_resp_data_d  = bus.mem_resp_data;
                        ic_resp_valid_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                mem_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            last_dc_q       <= 1'b0;
            owner_dc_q      <= 1'b0;
            rw_q            <= 1'b0;
            addr_q          <= '0;
            data_q          <= '0;
            mask_q          <= '0;
            mem_valid_q     <= 1'b0;
            ic_resp_valid_q <= 1'b0;
            dc_resp_valid_q <= 1'b0;
            ic_resp_data_q  <= '0;
            dc_resp_data_q  <= '0;
        end else begin
            state_q         <= state_d;
            last_dc_q       <= last_dc_d;
            owner_dc_q      <= owner_dc_d;
            rw_q            <= rw_d;
            addr_q          <= addr_d;
            data_q          <= data_d;
            mask_q          <= mask_d;
            mem_valid_q     <= mem_valid_d;
            ic_resp_valid_q <= ic_resp_valid_d;
            dc_resp_valid_q <= dc_resp_valid_d;
            ic_resp_data_q  <= ic_resp_data_d;
            dc_resp_data_q  <= dc_resp_data_d;
        end
    end

    assign bus.ic_req_ready  = w_grant_ic;
    assign bus.dc_req_ready  = w_grant_dc;
    assign bus.ic_resp_valid = ic_resp_valid_q;
    assign bus.ic_resp_data  = ic_resp_data_q;
    assign bus.dc_resp_valid = dc_resp_valid_q;
    assign bus.dc_resp_data  = dc_resp_data_q;
    assign bus.mem_req_valid = mem_valid_q;
    assign bus.mem_req_rw    = rw_q;
    assign bus.mem_req_addr  = addr_q;
    assign bus.mem_req_data  = data_q;
    assign bus.mem_req_mask  = mask_q;
    assign busy              = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 28: line-address width (32-bit byte address, 16-byte lines).
REQ-002 Parameter LINE_W, default 128: cache line data width; mask width is LINE_W/8.
REQ-003 Clocking SHALL be a single clock `clk`, and reset SHALL be `reset`, synchronous, active-high.
REQ-004 clk  in  1  clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 ic_req_valid  in  1  icache refill read request.
REQ-007 ic_req_ready  out  1  icache request accepted this cycle when high with valid.
REQ-008 ic_req_addr  in  ADDR_W  icache line address.
REQ-009 ic_resp_valid  out  1  one-cycle pulse, icache read data valid.
REQ-010 ic_resp_data  out  LINE_W  icache read line.
REQ-011 dc_req_valid  in  1  dcache request.
REQ-012 dc_req_ready  out  1  dcache request accepted when high with valid.
REQ-013 dc_req_rw  in  1  1 = write, 0 = read.
REQ-014 dc_req_addr  in  ADDR_W  dcache line address.
REQ-015 dc_req_data / dc_req_mask  in  LINE_W / LINE_W/8  write line and byte enables.
REQ-016 dc_resp_valid  out  1  one-cycle pulse, dcache read data valid.
REQ-017 dc_resp_data  out  LINE_W  dcache read line.
REQ-018 mem_req_valid  out  1  request to main memory.
REQ-019 mem_req_ready  in  1  memory accepts request.
REQ-020 mem_req_rw / mem_req_addr / mem_req_data / mem_req_mask  out  1 / ADDR_W / LINE_W / LINE_W/8  forwarded request fields.
REQ-021 mem_resp_valid / mem_resp_data  in  1 / LINE_W  read response.
REQ-022 busy  out  1  high whenever state != IDLE.

Function
REQ-023 FSM states SHALL be IDLE, ISSUE and WAIT; at most one memory transaction outstanding.
REQ-024 IDLE: exactly the granted requester sees its req_ready=1 (combinational from valids and pointer); the other sees 0; no valids means both readies 0.
REQ-025 Grant: only one valid -> that one; both valid -> requester not granted last (round-robin pointer); pointer updates on each acceptance.
REQ-026 On acceptance, owner, rw, addr, data and mask SHALL be latched; icache requests latch rw=0, mask=0; dcache reads latch mask=0; next state ISSUE.
REQ-027 ISSUE: mem_req_valid=1 with latched fields held stable until mem_req_ready=1; both req_ready=0.
REQ-028 ISSUE handshake with rw=1 -> IDLE, no response pulse; with rw=0 -> WAIT.
REQ-029 WAIT: on mem_resp_valid, latch mem_resp_data into owner's resp_data, assert owner's resp_valid exactly one cycle later, return to IDLE in that same later cycle.
REQ-030 mem_resp_valid outside WAIT SHALL be ignored; non-owner resp_valid never asserts.
REQ-031 Minimum read latency: acceptance cycle N, mem_req_valid cycle N+1, resp_valid one cycle after mem_resp_valid; next acceptance no earlier than the resp_valid cycle.
REQ-032 resp_data registers SHALL hold last value until next response to that owner.
REQ-033 Requester dropping req_valid while not accepted SHALL have no effect; inputs are don't-care outside acceptance cycle.

Reset
REQ-034 Reset SHALL force state IDLE, mem_req_valid=0, both resp_valid=0, busy=0, resp_data registers 0, latched request fields 0.
REQ-035 Round-robin pointer SHALL reset so dcache wins the first simultaneous request.
REQ-036 Reset mid-transaction SHALL abandon it; no response pulse follows, any later mem_resp_valid is ignored.

Verification
REQ-037 Both valid from reset, addr ic=0x0000100, dc=0x0000200 read -> dc granted first, mem_req_addr=0x0000200, then ic granted, mem_req_addr=0x0000100.
REQ-038 dc write addr 0x0000040, mask 0xFFFF, mem_req_ready held 0 for 3 cycles -> fields stable 3 cycles, IDLE after handshake, no dc_resp_valid.
REQ-039 ic read, mem_resp_valid with data 0xDEADBEEF_... -> ic_resp_valid one cycle later for one cycle, ic_resp_data matches, dc_resp_valid stays 0.
REQ-040 Stray mem_resp_valid in IDLE and ISSUE -> no resp_valid, state unchanged.
REQ-041 Reset asserted in WAIT, then mem_resp_valid -> busy=0, no resp_valid, next dc request accepted normally.
REQ-042 Both requesters continuously valid for 6 transactions -> strict alternation dc, ic, dc, ic, dc, ic.
